// File: rtl/pcie_chn_arb_if.sv
// rtl/pcie_chn_arb_if.sv - channel-side request/drive/token bundle for the endpoint arbiter
interface pcie_chn_arb_if #(
  parameter int NUM_CHN = 2
);
  logic [NUM_CHN-1:0] chn_reqep;
  logic [NUM_CHN-1:0] chn_drvn;
  logic [NUM_CHN-1:0] chn_trn;
  logic [3:0]         trn_tbuf_av;

  modport master (
    output chn_reqep,
    output chn_drvn,
    output trn_tbuf_av,
    input  chn_trn
  );

  modport slave (
    input  chn_reqep,
    input  chn_drvn,
    input  trn_tbuf_av,
    output chn_trn
  );
endinterface

// File: rtl/pcie_chn_arb.sv
// rtl/pcie_chn_arb.sv - round-robin TRN tx token arbiter across endpoint channels
// Token is revoked on request drop or start timeout, and one dead cycle separates owners.
module pcie_chn_arb #(
  parameter int NUM_CHN    = 2,
  parameter int GRANT_TO   = 64,
  parameter int MIN_BUF_AV = 1,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  pcie_chn_arb_if.slave    bus,
  output logic             o_grant_vld,
  output logic [2:0]       o_grant_idx,
  output logic             o_arb_err,
  output logic [CNT_W-1:0] o_timeout_cnt,
  output logic [CNT_W-1:0] o_grant_cnt
);
  localparam int WAIT_W = $clog2(GRANT_TO);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_GAP} state_t;

  state_t             r_state;
  logic [2:0]         r_ptr;
  logic [WAIT_W-1:0]  r_wait;
  logic [NUM_CHN-1:0] r_chn_trn;
  logic               r_grant_vld;
  logic [2:0]         r_grant_idx;
  logic               r_arb_err;
  logic [CNT_W-1:0]   r_timeout_cnt;
  logic [CNT_W-1:0]   r_grant_cnt;

  logic [7:0] w_req8;
  logic [7:0] w_drvn8;
  logic [7:0] w_pick_oh;
  logic [7:0] w_own_oh;
  logic [3:0] w_sum;
  logic [2:0] w_pick;
  logic       w_pick_vld;
  logic       w_can_grant;
  logic [2:0] w_ptr_nxt;
  logic       w_own_drvn;
  logic       w_own_req;
  logic       w_err;

  assign w_req8  = 8'(bus.chn_reqep);
  assign w_drvn8 = 8'(bus.chn_drvn);

  // Highest-priority requester is the first one found at or after r_ptr.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_sum      = '0;
    for (int i = NUM_CHN - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + 4'(i);
      if (w_sum >= 4'(NUM_CHN)) w_sum = w_sum - 4'(NUM_CHN);
      if (w_req8[w_sum[2:0]]) begin
        w_pick     = w_sum[2:0];
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_pick_oh   = 8'd1 << w_pick;
  assign w_own_oh    = 8'd1 << r_grant_idx;
  assign w_can_grant = w_pick_vld && (bus.trn_tbuf_av >= 4'(MIN_BUF_AV));
  assign w_ptr_nxt   = (r_grant_idx == 3'(NUM_CHN - 1)) ? 3'd0 : r_grant_idx + 3'd1;
  assign w_own_drvn  = w_drvn8[r_grant_idx];
  assign w_own_req   = w_req8[r_grant_idx];
  assign w_err       = (r_grant_vld && ((w_drvn8 & ~w_own_oh) != 8'd0)) ||
                       ((r_state == ST_IDLE) && (w_drvn8 != 8'd0));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_wait        <= '0;
      r_chn_trn     <= '0;
      r_grant_vld   <= 1'b0;
      r_grant_idx   <= '0;
      r_arb_err     <= 1'b0;
      r_timeout_cnt <= '0;
      r_grant_cnt   <= '0;
    end else begin
      if (w_err) r_arb_err <= 1'b1;
      case (r_state)
        // GAP's exit edge already arbitrates, so the dead time is exactly one cycle.
        ST_IDLE, ST_GAP: begin
          if (w_can_grant) begin
            r_chn_trn   <= w_pick_oh[NUM_CHN-1:0];
            r_grant_idx <= w_pick;
            r_grant_vld <= 1'b1;
            r_wait      <= '0;
            r_state     <= ST_GRANT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_own_drvn) begin
            r_state <= ST_BUSY;
            if (~&r_grant_cnt) r_grant_cnt <= r_grant_cnt + CNT_W'(1);
          end else if (!w_own_req || (r_wait == WAIT_W'(GRANT_TO - 1))) begin
            r_chn_trn   <= '0;
            r_grant_vld <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_state     <= ST_GAP;
            if (w_own_req && (~&r_timeout_cnt)) r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_BUSY: begin
          if (!w_own_drvn) begin
            r_chn_trn   <= '0;
            r_grant_vld <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_state     <= ST_GAP;
          end
        end
      endcase
    end
  end

  assign bus.chn_trn   = r_chn_trn;
  assign o_grant_vld   = r_grant_vld;
  assign o_grant_idx   = r_grant_idx;
  assign o_arb_err     = r_arb_err;
  assign o_timeout_cnt = r_timeout_cnt;
  assign o_grant_cnt   = r_grant_cnt;
endmodule

// File: tb/tb_pcie_chn_arb.sv
// tb/tb_pcie_chn_arb.sv - directed stimulus with an owner/age reference model for pcie_chn_arb
module tb_pcie_chn_arb;
  localparam int NCH    = 2;
  localparam int GTO    = 64;
  localparam int MIN_AV = 1;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          grant_vld;
  logic [2:0]    grant_idx;
  logic          arb_err;
  logic [CW-1:0] timeout_cnt;
  logic [CW-1:0] grant_cnt;

  int n_chk;
  int n_err;
  int cnt;
  bit run;

  pcie_chn_arb_if #(.NUM_CHN(NCH)) bus();

  pcie_chn_arb #(
    .NUM_CHN(NCH), .GRANT_TO(GTO), .MIN_BUF_AV(MIN_AV), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_grant_vld(grant_vld), .o_grant_idx(grant_idx), .o_arb_err(arb_err),
    .o_timeout_cnt(timeout_cnt), .o_grant_cnt(grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who owns the token, whether it has started driving, how long it has waited.
  typedef struct packed {
    int   owner;
    int   age;
    int   nxt;
    int   tmo;
    int   gnt;
    logic driving;
    logic dead;
    logic err;
  } mdl_t;

  mdl_t m;
  mdl_t mn;
  int   pick;

  always_comb begin
    mn   = m;
    pick = -1;
    if (m.owner >= 0) begin
      if ((int'(bus.chn_drvn) & ~(1 << m.owner)) != 0) mn.err = 1'b1;
    end else if (!m.dead && bus.chn_drvn != '0) begin
      mn.err = 1'b1;
    end
    if (m.owner < 0) begin
      mn.dead = 1'b0;
      if (int'(bus.trn_tbuf_av) >= MIN_AV)
        for (int k = 0; k < NCH; k++)
          if (pick < 0 && bus.chn_reqep[(m.nxt + k) % NCH]) pick = (m.nxt + k) % NCH;
      if (pick >= 0) begin
        mn.owner   = pick;
        mn.driving = 1'b0;
        mn.age     = 0;
      end
    end else if (!m.driving) begin
      if (bus.chn_drvn[m.owner]) begin
        mn.driving = 1'b1;
        mn.gnt     = (m.gnt < CMAX) ? m.gnt + 1 : CMAX;
      end else if (!bus.chn_reqep[m.owner] || m.age == GTO - 1) begin
        if (bus.chn_reqep[m.owner]) mn.tmo = (m.tmo < CMAX) ? m.tmo + 1 : CMAX;
        mn.owner = -1;
        mn.dead  = 1'b1;
        mn.nxt   = (m.owner + 1) % NCH;
      end else begin
        mn.age = m.age + 1;
      end
    end else if (!bus.chn_drvn[m.owner]) begin
      mn.owner   = -1;
      mn.driving = 1'b0;
      mn.dead    = 1'b1;
      mn.nxt     = (m.owner + 1) % NCH;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      m.owner <= -1;
    end else begin
      m <= mn;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("trn", int'(bus.chn_trn), (m.owner >= 0) ? (1 << m.owner) : 0);
      chk("grant_vld", int'(grant_vld), (m.owner >= 0) ? 1 : 0);
      if (m.owner >= 0) chk("grant_idx", int'(grant_idx), m.owner);
      chk("arb_err", int'(arb_err), int'(m.err));
      chk("timeout_cnt", int'(timeout_cnt), m.tmo);
      chk("grant_cnt", int'(grant_cnt), m.gnt);
    end
  end

  task automatic serve(input int ch, input int n, input int exp_next);
    bus.chn_drvn = NCH'(1 << ch);
    repeat (n) @(negedge clk);
    bus.chn_drvn = '0;
    @(negedge clk);
    chk("gap_trn", int'(bus.chn_trn), 0);
    @(negedge clk);
    chk("next_trn", int'(bus.chn_trn), exp_next);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    run   = 1'b0;
    rst_n = 1'b0;
    bus.chn_reqep   = '0;
    bus.chn_drvn    = '0;
    bus.trn_tbuf_av = 4'd4;
    repeat (3) @(negedge clk);
    run = 1'b1;
    chk("rst_trn", int'(bus.chn_trn), 0);
    chk("rst_vld", int'(grant_vld), 0);
    chk("rst_err", int'(arb_err), 0);
    chk("rst_tmo", int'(timeout_cnt), 0);

    // Alternation between two steady requesters
    rst_n = 1'b1;
    bus.chn_reqep = 2'b11;
    @(negedge clk);
    chk("t1_first", int'(bus.chn_trn), 1);
    serve(0, 3, 2);
    serve(1, 2, 1);
    serve(0, 1, 2);

    // ch1 alone never drives: 64-cycle hold, one dead cycle, regrant
    bus.chn_reqep = 2'b10;
    cnt = 0;
    while (bus.chn_trn == 2'b10 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("t2_hold", cnt, 64);
    chk("t2_gap", int'(bus.chn_trn), 0);
    @(negedge clk);
    chk("t2_regrant", int'(bus.chn_trn), 2);
    chk("t2_tmo", int'(timeout_cnt), 1);
    repeat (18 * 66) @(negedge clk);
    chk("t6_sat", int'(timeout_cnt), 15);

    // No buffer space holds off the grant
    bus.chn_reqep = '0;
    @(negedge clk);
    bus.trn_tbuf_av = 4'd0;
    bus.chn_reqep   = 2'b11;
    repeat (4) @(negedge clk);
    chk("t3_nogrant", int'(bus.chn_trn), 0);
    bus.trn_tbuf_av = 4'd1;
    @(negedge clk);
    chk("t3_latency", int'(bus.chn_trn), 1);

    // Foreign drvn during ch0 BUSY
    bus.chn_drvn = 2'b01;
    @(negedge clk);
    bus.chn_drvn = 2'b11;
    @(negedge clk);
    chk("t4_err", int'(arb_err), 1);
    chk("t4_keep", int'(bus.chn_trn), 1);
    bus.chn_drvn = 2'b01;
    repeat (3) @(negedge clk);
    chk("t4_sticky", int'(arb_err), 1);
    chk("t4_keep2", int'(bus.chn_trn), 1);

    // Lone ch0 re-granted past ptr=1, then reset while it is BUSY
    bus.chn_drvn  = '0;
    bus.chn_reqep = 2'b01;
    @(negedge clk);
    chk("t5_gap", int'(bus.chn_trn), 0);
    @(negedge clk);
    chk("t5_lone", int'(bus.chn_trn), 1);
    bus.chn_drvn = 2'b01;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_trn", int'(bus.chn_trn), 0);
    chk("t5_async_vld", int'(grant_vld), 0);
    chk("t5_async_err", int'(arb_err), 0);
    chk("t5_async_gnt", int'(grant_cnt), 0);
    bus.chn_drvn  = '0;
    bus.chn_reqep = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ptr0", int'(bus.chn_trn), 1);

    // drvn wins over a simultaneous request drop
    bus.chn_reqep = 2'b00;
    bus.chn_drvn  = 2'b01;
    @(negedge clk);
    chk("prio_busy", int'(bus.chn_trn), 1);
    chk("prio_gnt", int'(grant_cnt), 1);
    bus.chn_drvn = '0;
    repeat (3) @(negedge clk);
    chk("idle_trn", int'(bus.chn_trn), 0);
    bus.chn_drvn = 2'b10;
    @(negedge clk);
    chk("idle_err", int'(arb_err), 1);
    bus.chn_drvn = '0;
    @(negedge clk);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
